// File: rtl/gpio_in_filter_if.sv
// rtl/gpio_in_filter_if.sv - pad input, filter config and filtered output bundle for gpio_in_filter
//
// Signals:
//   pad_i      raw asynchronous pad levels
//   flt_en_i   per-pin filter enable (0 = synchronise only)
//   flt_div_i  sample tick period minus 1
//   flt_thr_i  consecutive differing ticks needed to flip a pin (0 acts as 1)
//   gpio_o     filtered pin levels
//   chg_o      one-cycle change pulse per pin
// Modports: master drives pads/config and observes outputs; slave is the filter.

interface gpio_in_filter_if #(
    parameter int GPIO_NUM  = 32,
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
);
    logic [GPIO_NUM-1:0]  pad_i;
    logic [GPIO_NUM-1:0]  flt_en_i;
    logic [DIV_WIDTH-1:0] flt_div_i;
    logic [CNT_WIDTH-1:0] flt_thr_i;
    logic [GPIO_NUM-1:0]  gpio_o;
    logic [GPIO_NUM-1:0]  chg_o;

    modport master (
        output pad_i,
        output flt_en_i,
        output flt_div_i,
        output flt_thr_i,
        input  gpio_o,
        input  chg_o
    );

    modport slave (
        input  pad_i,
        input  flt_en_i,
        input  flt_div_i,
        input  flt_thr_i,
        output gpio_o,
        output chg_o
    );
endinterface

// File: rtl/gpio_in_filter.sv
// rtl/gpio_in_filter.sv - pad input synchroniser and per-pin debounce filter
//
// Ports:
//   pclk     clock
//   presetn  asynchronous active-low reset
//   bus      gpio_in_filter_if.slave: pad_i, flt_en_i, flt_div_i, flt_thr_i in;
//            gpio_o, chg_o out (both registered)
//
// Each pin passes through a 2-FF synchroniser. With the filter disabled the
// synchronised level goes straight to gpio_o. With it enabled, gpio_o only
// flips after thr_eff consecutive sample ticks that all disagree with it;
// any agreeing tick clears the count. All pins share one sample prescaler.

module gpio_in_filter #(
    parameter int GPIO_NUM  = 32,
    parameter int CNT_WIDTH = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    gpio_in_filter_if.slave   bus
);

    logic [GPIO_NUM-1:0]  s1_q, s1_d;
    logic [GPIO_NUM-1:0]  s2_q, s2_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q [GPIO_NUM];
    logic [CNT_WIDTH-1:0] cnt_d [GPIO_NUM];
    logic [GPIO_NUM-1:0]  gpio_q, gpio_d;
    logic [GPIO_NUM-1:0]  chg_q, chg_d;

    logic                 tick;
    logic [CNT_WIDTH:0]   thr_eff;

    always_comb begin
        s1_d      = bus.pad_i;
        s2_d      = s1_q;

        // >= rather than == so that shrinking the period below the current
        // count produces a tick immediately instead of wrapping around.
        tick      = (div_cnt_q >= bus.flt_div_i);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

        // One extra bit so cnt + 1 cannot overflow in the compare below.
        thr_eff   = (bus.flt_thr_i == '0) ? (CNT_WIDTH+1)'(1)
                                          : {1'b0, bus.flt_thr_i};

        gpio_d    = gpio_q;
        for (int i = 0; i < GPIO_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!bus.flt_en_i[i]) begin
                gpio_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (tick) begin
                if (s2_q[i] == gpio_q[i]) begin
                    cnt_d[i] = '0;
                end else if (({1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(1)) >= thr_eff) begin
                    gpio_d[i] = s2_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        chg_d     = gpio_d ^ gpio_q;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            div_cnt_q <= '0;
            gpio_q    <= '0;
            chg_q     <= '0;
            for (int i = 0; i < GPIO_NUM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            div_cnt_q <= div_cnt_d;
            gpio_q    <= gpio_d;
            chg_q     <= chg_d;
            for (int i = 0; i < GPIO_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.gpio_o = gpio_q;
    assign bus.chg_o  = chg_q;

endmodule
